// File: rtl/counter_pkg.sv
// Shared sizing for the free-running counter.
// Users of tc size their loops from these values.
package counter_pkg;

  localparam int COUNTER_WIDTH = 5;

  function automatic int counter_terminal(input int width);
    return (2 ** width) - 1;
  endfunction

  localparam int COUNTER_TERMINAL = counter_terminal(COUNTER_WIDTH);

endpackage

// File: rtl/counter.sv
// Free-running up-counter, 0..TERMINAL then wrap.
// tc flags the last state of each pass.
module counter
  import counter_pkg::*;
#(
  parameter int WIDTH    = COUNTER_WIDTH,
  parameter int TERMINAL = counter_terminal(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  if (TERMINAL < 1 || TERMINAL >= (2 ** WIDTH)) begin : g_bad_terminal
    $error("counter: TERMINAL out of range 1..2**WIDTH-1");
  end

  localparam logic [WIDTH-1:0] TERM_V = TERMINAL[WIDTH-1:0];

  // Power-up value keeps count and tc defined before the first reset.
  logic [WIDTH-1:0] count_q = '0;
  logic             at_term;

  assign at_term = (count_q == TERM_V);

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (at_term) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;
  assign tc    = at_term;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    assert (tc == (count == TERM_V))
      else $error("counter: tc inconsistent with count");
    assert (count <= TERM_V)
      else $error("counter: count above TERMINAL");
  end
`endif

endmodule

// File: tb/tb_counter.sv
// Scoreboard bench for counter: default and WIDTH=4/TERMINAL=9.
// Expected values come from a bench-side reference model.
module tb_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] count0;
  logic       tc0;
  logic [3:0] count1;
  logic       tc1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int c0;
    bit t0;
    int c1;
    bit t1;
  } exp_t;

  exp_t sb[$];
  int   m0 = 0;
  int   m1 = 0;

  always #5 clk = ~clk;

  counter u_dut0 (
    .clk   (clk),
    .rst   (rst),
    .count (count0),
    .tc    (tc0)
  );

  counter #(.WIDTH(4), .TERMINAL(9)) u_dut1 (
    .clk   (clk),
    .rst   (rst),
    .count (count1),
    .tc    (tc1)
  );

  function automatic int model_next(input int c, input int term, input bit r);
    if (r) return 0;
    if (c == term) return 0;
    return c + 1;
  endfunction

  task automatic check(input string tag, input int obs, input int exp_v, input bit known);
    tests++;
    assert (known && obs === exp_v)
      else begin
        fails++;
        $error("FAIL %s: observed %0d (known=%0b) expected %0d", tag, obs, known, exp_v);
      end
  endtask

  task automatic check_outputs();
    exp_t e;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL scoreboard: observed empty queue expected an entry");
      return;
    end
    e = sb.pop_front();
    check("count0", int'(count0), e.c0, !$isunknown(count0));
    check("tc0", int'(tc0), int'(e.t0), !$isunknown(tc0));
    check("count1", int'(count1), e.c1, !$isunknown(count1));
    check("tc1", int'(tc1), int'(e.t1), !$isunknown(tc1));
  endtask

  // Drive rst for one edge, predict, then sample 1 ns after the edge.
  task automatic step(input bit r);
    exp_t e;
    rst = r;
    m0 = model_next(m0, 31, r);
    m1 = model_next(m1, 9, r);
    e.c0 = m0;
    e.t0 = (m0 == 31);
    e.c1 = m1;
    e.t1 = (m1 == 9);
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic run(input int n, input bit r);
    for (int i = 0; i < n; i++) step(r);
  endtask

  initial begin
    #1;
    check("pwrup_count0", int'(count0), 0, !$isunknown(count0));
    check("pwrup_tc0", int'(tc0), 0, !$isunknown(tc0));
    check("pwrup_count1", int'(count1), 0, !$isunknown(count1));
    check("pwrup_tc1", int'(tc1), 0, !$isunknown(tc1));

    // Free-running before any reset: edges at 5..95 ns.
    run(10, 1'b0);
    // Reset held across edges 105..195 ns.
    run(10, 1'b1);
    check("rst_hold_count0", int'(count0), 0, 1'b1);

    // First edge after release gives 1.
    step(1'b0);
    check("first_edge", int'(count0), 1, 1'b1);
    run(16, 1'b0);
    check("at17", int'(count0), 17, 1'b1);

    // Mid-count reset at 17.
    step(1'b1);
    check("rst_at17", int'(count0), 0, 1'b1);
    step(1'b0);
    check("after_rst17", int'(count0), 1, 1'b1);

    run(30, 1'b0);
    check("term_count", int'(count0), 31, 1'b1);
    check("term_tc", int'(tc0), 1, 1'b1);

    // Reset at the terminal value: restart at 0, never 32.
    step(1'b1);
    check("rst_at31", int'(count0), 0, 1'b1);
    step(1'b0);
    check("after_rst31", int'(count0), 1, 1'b1);

    // Several full passes to cover wrap for both instances.
    run(30, 1'b0);
    check("wrap_pre", int'(count0), 31, 1'b1);
    step(1'b0);
    check("wrap_to0", int'(count0), 0, 1'b1);
    check("wrap_tc0", int'(tc0), 0, 1'b1);
    run(70, 1'b0);

    check("sb_drained", sb.size(), 0, 1'b1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish before 100 us");
    $fatal(1, "timeout");
  end

endmodule
